// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle unsigned restoring divider. A division is requested with a
// one-cycle start pulse while idle. A normal division takes WIDTH iterations,
// one per clock. A zero divisor skips the iterations and reports divide-by-zero.
// Results stay on the outputs until the next accepted request completes.
//
// Parameters:
//   WIDTH  operand, quotient and remainder width; also the iteration count.
//          Must be at least 2.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset; aborts a running division
//   start  in   1      division request, sampled only while idle
//   A      in   WIDTH  dividend, needed only in the start cycle
//   B      in   WIDTH  divisor, needed only in the start cycle
//   busy   out  1      high while a division is running or completing
//   done   out  1      one-cycle pulse when Q, R, z and dz are valid
//   Q      out  WIDTH  quotient (all ones on divide-by-zero)
//   R      out  WIDTH  remainder (the dividend on divide-by-zero)
//   z      out  1      quotient is zero
//   dz     out  1      divide-by-zero occurred
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             z,
   output logic             dz
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] quo_reg;   // dividend shifts out of the top, quotient bits in at the bottom
   logic [WIDTH-1:0] div_reg;   // latched divisor
   logic [WIDTH-1:0] rem_reg;   // partial remainder
   logic [CNT_W-1:0] cnt_reg;   // iteration counter

   // The partial remainder is WIDTH+1 bits wide conceptually, but after every
   // iteration it is strictly smaller than the divisor, so its top bit is
   // always zero and is not stored. The extra bit only exists in the
   // candidate/trial arithmetic below.
   logic [WIDTH:0]   cand;
   logic [WIDTH:0]   trial;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic             last_iter;

   assign cand      = {rem_reg, quo_reg[WIDTH-1]};
   assign trial     = cand - {1'b0, div_reg};
   assign no_borrow = ~trial[WIDTH];
   // When the trial borrows, cand[WIDTH] is necessarily 0 (otherwise the
   // candidate would exceed any WIDTH-bit divisor), so dropping it is safe.
   assign rem_next  = no_borrow ? trial[WIDTH-1:0] : cand[WIDTH-1:0];
   assign quo_next  = {quo_reg[WIDTH-2:0], no_borrow};
   assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         quo_reg   <= '0;
         div_reg   <= '0;
         rem_reg   <= '0;
         cnt_reg   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         Q         <= '0;
         R         <= '0;
         z         <= 1'b0;
         dz        <= 1'b0;
      end else begin
         // done is a single-cycle pulse; it is set only on entry to DONE.
         done <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (B != '0) begin
                     quo_reg   <= A;
                     div_reg   <= B;
                     rem_reg   <= '0;
                     cnt_reg   <= '0;
                     state_reg <= RUN;
                  end else begin
                     // Divide-by-zero: report immediately, no iterations.
                     Q         <= '1;
                     R         <= A;
                     z         <= 1'b0;
                     dz        <= 1'b1;
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end

            RUN: begin
               quo_reg <= quo_next;
               rem_reg <= rem_next;
               cnt_reg <= cnt_reg + 1'b1;
               if (last_iter) begin
                  // Publish the results of this final iteration directly so
                  // done lines up with valid outputs in the DONE cycle.
                  Q         <= quo_next;
                  R         <= rem_next;
                  z         <= (quo_next == '0);
                  dz        <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end
            end

            DONE: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end

            default: begin
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
